bitonic_unloader_16: RTL

BITONIC_UNLOADER_16 -- requirements
Module: bitonic_unloader_16

---
 rtl/bitonic_pkg.sv | 8 +
 rtl/bitonic_vec_fifo.sv | 53 +++++
 rtl/bitonic_unloader_16.sv | 100 ++++++++++
 3 files changed

// File: rtl/bitonic_pkg.sv
// bitonic_pkg: shared sorter constants, element type and serializer state encoding.
package bitonic_pkg;
    localparam int DATAWIDTH  = 8;
    localparam int DATALENGTH = 16;
    localparam int LATENCY    = 4;
    typedef logic [DATAWIDTH-1:0] data_t;
    typedef enum logic {IDLE, EMIT} state_e;
endpackage

// File: rtl/bitonic_vec_fifo.sv
// bitonic_vec_fifo: DEPTH-entry circular store of sorted vectors plus their emit counts.
module bitonic_vec_fifo #(
    parameter int DATAWIDTH  = 8,
    parameter int DATALENGTH = 16,
    parameter int KW         = 5,
    parameter int DEPTH      = 4,
    localparam int IW = $clog2(DATALENGTH),
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 wr_i,
    input  logic [DATAWIDTH-1:0] wr_data_i [DATALENGTH],
    input  logic [KW-1:0]        wr_k_i,
    input  logic                 rd_i,
    input  logic [IW-1:0]        rd_idx_i,
    output logic [DATAWIDTH-1:0] rd_data_o,
    output logic [KW-1:0]        rd_k_o,
    output logic [CW-1:0]        count_o
);
    logic [DATAWIDTH-1:0] mem_q [DEPTH][DATALENGTH];
    logic [KW-1:0]        k_q [DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (wr_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
            k_q[wr_ptr_q]   <= wr_k_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_i ? nxt(wr_ptr_q) : wr_ptr_q;
            rd_ptr_q <= rd_i ? nxt(rd_ptr_q) : rd_ptr_q;
            count_q  <= count_q + CW'(wr_i) - CW'(rd_i);
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q][rd_idx_i];
    assign rd_k_o    = k_q[rd_ptr_q];
    assign count_o   = count_q;
endmodule

// File: rtl/bitonic_unloader_16.sv
// bitonic_unloader_16: credits sorter launches, captures sorted vectors after LATENCY
// cycles and serializes the first k elements of each through a valid/ready port.
module bitonic_unloader_16 #(
    parameter int DATAWIDTH  = bitonic_pkg::DATAWIDTH,
    parameter int DATALENGTH = bitonic_pkg::DATALENGTH,
    parameter int LATENCY    = bitonic_pkg::LATENCY,
    parameter int DEPTH      = 4,
    localparam int KW = $clog2(DATALENGTH) + 1,
    localparam int IW = $clog2(DATALENGTH)
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 launch_valid_i,
    output logic                 launch_ready_o,
    input  logic [KW-1:0]        k_i,
    input  logic [DATAWIDTH-1:0] sorted_i [DATALENGTH],
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DATAWIDTH-1:0] out_data_o,
    output logic [IW-1:0]        out_index_o,
    output logic                 out_last_o
);
    import bitonic_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    logic [LATENCY-1:0]   dl_v_q;
    logic [KW-1:0]        dl_k_q [LATENCY];
    logic [CW-1:0]        credit_q;
    state_e               state_q;
    logic [IW-1:0]        idx_q;
    logic                 accept, wr, hs, last, pop;
    logic [KW-1:0]        k_clamped, head_k;
    logic [CW-1:0]        fifo_count;
    logic [DATAWIDTH-1:0] head_data;

    // Credit covers in-flight launches too, so a landing vector always finds a free slot.
    assign launch_ready_o = credit_q < CW'(DEPTH);
    assign accept         = launch_valid_i && launch_ready_o;
    assign k_clamped      = (k_i == '0 || k_i > KW'(DATALENGTH)) ? KW'(DATALENGTH) : k_i;
    assign wr             = dl_v_q[LATENCY-1];
    assign out_valid_o    = state_q == EMIT;
    assign last           = out_valid_o && ({1'b0, idx_q} == head_k - KW'(1));
    assign hs             = out_valid_o && out_ready_i;
    assign pop            = hs && last;
    assign out_last_o     = last;
    assign out_index_o    = idx_q;
    assign out_data_o     = out_valid_o ? head_data : '0;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            dl_v_q <= '0;
            for (int i = 0; i < LATENCY; i++) dl_k_q[i] <= '0;
            credit_q <= '0;
        end else begin
            for (int i = 1; i < LATENCY; i++) begin
                dl_v_q[i] <= dl_v_q[i-1];
                dl_k_q[i] <= dl_k_q[i-1];
            end
            dl_v_q[0] <= accept;
            dl_k_q[0] <= k_clamped;
            credit_q  <= credit_q + CW'(accept) - CW'(pop);
        end
    end

    // A vector landing this edge counts as buffered, so emission starts without a bubble.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (fifo_count != '0 || wr) state_q <= EMIT;
                EMIT: if (hs) begin
                    idx_q <= last ? '0 : idx_q + IW'(1);
                    if (last && fifo_count == CW'(1) && !wr) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    bitonic_vec_fifo #(
        .DATAWIDTH (DATAWIDTH),
        .DATALENGTH(DATALENGTH),
        .KW        (KW),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .wr_i     (wr),
        .wr_data_i(sorted_i),
        .wr_k_i   (dl_k_q[LATENCY-1]),
        .rd_i     (pop),
        .rd_idx_i (idx_q),
        .rd_data_o(head_data),
        .rd_k_o   (head_k),
        .count_o  (fifo_count)
    );
endmodule
